twiddle_fetch_sequencer: RTL

- Reader side of the per-stage twiddle ROMs in the (I)FFT datapath.
- On `start`, it walks every butterfly of a radix-2 DIT transform in stage order and drives the ROM address.
- It pairs the returned real and imaginary twiddles with butterfly operand indices and hands them to the butterfly unit over a valid/ready stream.
- Full throughput of one butterfly per cycle; backpressure absorbed by a 2-entry output buffer.

---
 rtl/twiddle_fetch_sequencer.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/twiddle_fetch_sequencer.sv
// twiddle_fetch_sequencer
// Walks every butterfly of a radix-2 DIT transform in stage order. For each
// one it drives the shared twiddle ROM address, tags the returned real and
// imaginary words with stage and operand indices, and presents the result on
// a valid/ready stream through a 2-entry FIFO. It sustains one butterfly per
// cycle when the consumer does not stall.
//
// Build option: define TW_CONJ_EN to present the saturating negation of the
// imaginary twiddle, which conjugates inverse-FFT tables for forward use.
module twiddle_fetch_sequencer #(
  parameter int LOG2N = 5,
  parameter int DW    = 16,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    rom_addr,
  input  logic [DW-1:0]    rom_data_re,
  input  logic [DW-1:0]    rom_data_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       out_stage,
  output logic [LOG2N-1:0] out_idx_a,
  output logic [LOG2N-1:0] out_idx_b,
  output logic [DW-1:0]    out_tw_re,
  output logic [DW-1:0]    out_tw_im
);

  localparam int N = 1 << LOG2N;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  // Stage and operand indices that travel alongside a ROM read.
  typedef struct packed {
    logic [2:0]       stage;
    logic [LOG2N-1:0] idx_a;
    logic [LOG2N-1:0] idx_b;
  } tag_t;

  // One complete butterfly descriptor as held in the output FIFO.
  typedef struct packed {
    tag_t          tag;
    logic [DW-1:0] tw_re;
    logic [DW-1:0] tw_im;
  } desc_t;

  state_t           state_q, state_d;
  logic [2:0]       s_q, n_s;
  logic [LOG2N-1:0] g_q, n_g;
  logic [LOG2N-1:0] k_q, n_k;
  logic [LOG2N:0]   half_w, grp_w;
  logic [LOG2N-1:0] half_m1, grp_m1;
  tag_t             cur_tag;
  logic             last_bfly;
  logic             start_ok;
  logic             issue;
  logic             pop;
  logic [2:0]       occupancy;

  logic             infl_q;
  tag_t             tag_q;
  logic [1:0]       count_q;
  desc_t            ent0_q, ent1_q;
  desc_t            push_desc;
  logic [DW-1:0]    im_fix;

  // Packed stage tables start at 2^s - 1, so the entry for (s, k) is base + k.
  function automatic logic [AW-1:0] tw_addr(input logic [2:0] s, input logic [LOG2N-1:0] k);
    logic [LOG2N:0] h;
    h = (LOG2N+1)'(1) << s;
    return AW'(h - (LOG2N+1)'(1)) + AW'(k);
  endfunction

  // Loop bounds, operand indices and successor position for the current butterfly.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    half_w    = (LOG2N+1)'(1) << s_q;
    grp_w     = (LOG2N+1)'(N) >> (s_q + 3'd1);
    half_m1   = LOG2N'(half_w - (LOG2N+1)'(1));
    grp_m1    = LOG2N'(grp_w - (LOG2N+1)'(1));
    cur_tag.stage = s_q;
    cur_tag.idx_a = LOG2N'(({1'b0, g_q} << (s_q + 3'd1)) + {1'b0, k_q});
    cur_tag.idx_b = cur_tag.idx_a + LOG2N'(half_w);
    last_bfly = (s_q == 3'(LOG2N - 1)) && (g_q == grp_m1) && (k_q == half_m1);
    n_s       = s_q;
    n_g       = g_q;
    n_k       = k_q + 1'b1;
    if (k_q == half_m1) begin
      n_k = '0;
      n_g = g_q + 1'b1;
      if (g_q == grp_m1) begin
        n_g = '0;
        n_s = (s_q == 3'(LOG2N - 1)) ? 3'd0 : s_q + 3'd1;
      end
    end
  end

  // Issue gating: a slot freed by this cycle's pop can be reused immediately.
  always_comb begin
    pop       = out_valid && out_ready;
    occupancy = {1'b0, count_q} + {2'b00, infl_q} - {2'b00, pop};
    issue     = (state_q == ST_RUN) && (occupancy < 3'd2);
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and the done pulse on the final handshake.
  always_comb begin
    state_d  = state_q;
    done     = 1'b0;
    start_ok = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_ok = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (issue && last_bfly) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (count_q == 2'd1 && !infl_q && pop) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q != ST_IDLE);

  // Butterfly position counters and ROM address; the address always points at
  // the butterfly that will issue next, and holds after the final issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q      <= '0;
      g_q      <= '0;
      k_q      <= '0;
      rom_addr <= '0;
    end else if (start_ok) begin
      s_q      <= '0;
      g_q      <= '0;
      k_q      <= '0;
      rom_addr <= '0;
    end else if (issue) begin
      s_q <= n_s;
      g_q <= n_g;
      k_q <= n_k;
      if (!last_bfly) rom_addr <= tw_addr(n_s, n_k);
    end
  end

  // Tag delay register: lines the tags up with ROM data one cycle after issue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      infl_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      infl_q <= issue;
      if (issue) tag_q <= cur_tag;
    end
  end

`ifdef TW_CONJ_EN
  // Saturating negation: the most negative code has no positive twin.
  assign im_fix = (rom_data_im == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}}
                                                           : -rom_data_im;
`else
  assign im_fix = rom_data_im;
`endif

  assign push_desc = '{tag: tag_q, tw_re: rom_data_re, tw_im: im_fix};

  // Two-entry FIFO; entry 0 is always the head so a stalled head never moves.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the FIFO entries are reset because they drive the outputs directly and must read 0 out of reset.
      count_q <= '0;
      ent0_q  <= '0;
      ent1_q  <= '0;
    end else begin
      case ({infl_q, pop})
        2'b10: begin
          if (count_q == 2'd0) ent0_q <= push_desc;
          else                 ent1_q <= push_desc;
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          ent0_q  <= ent1_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            ent0_q <= push_desc;
          end else begin
            ent0_q <= ent1_q;
            ent1_q <= push_desc;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_stage = ent0_q.tag.stage;
  assign out_idx_a = ent0_q.tag.idx_a;
  assign out_idx_b = ent0_q.tag.idx_b;
  assign out_tw_re = ent0_q.tw_re;
  assign out_tw_im = ent0_q.tw_im;

endmodule
